ex_stage_alu_flags: RTL and testbench

Execute stage of the 5-stage pipelined ARM CPU. It sits directly downstream of the ALU control unit and consumes its 3-bit `ALU_cntrl` encoding to run the datapath ALU on the ID/EX operands. It keeps the architectural NZCV flag register for ADDS/SUBS and produces the combinational zero indication that CBZ uses. It also owns the EX/MEM pipeline register, which supports stall and flush.

---
 rtl/ex_stage_alu_flags.sv | 165 ++++++++++++++++
 tb/tb_ex_stage_alu_flags.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_alu_flags.sv
// Execute stage: datapath ALU, NZCV flag register and the EX/MEM pipeline register.
module ex_stage_alu_flags #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_ALU_on,
  input  logic [2:0]       ALU_cntrl,
  input  logic             ex_set_flags,
  input  logic [WIDTH-1:0] ex_A,
  input  logic [WIDTH-1:0] ex_B,
  input  logic [WIDTH-1:0] ex_store_data,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] ex_result,
  output logic             ex_zero,
  output logic             mem_valid,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic [WIDTH-1:0] mem_result,
  output logic [WIDTH-1:0] mem_store_data,
  output logic [4:0]       mem_rd,
  output logic             flag_negative,
  output logic             flag_zero,
  output logic             flag_overflow,
  output logic             flag_carry
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [WIDTH:0] SUB_CIN = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             flag_upd;

  logic [3:0]       nzcv_d, nzcv_q;
  logic             mem_valid_d, mem_valid_q;
  logic             mem_reg_write_d, mem_reg_write_q;
  logic             mem_mem_read_d, mem_mem_read_q;
  logic             mem_mem_write_d, mem_mem_write_q;
  logic [WIDTH-1:0] mem_result_d, mem_result_q;
  logic [WIDTH-1:0] mem_store_data_d, mem_store_data_q;
  logic [4:0]       mem_rd_d, mem_rd_q;

  // ALU: unknown or unused encodings fall to the default arm so X never leaks out.
  always_comb begin
    add_full = {1'b0, ex_A} + {1'b0, ex_B};
    sub_full = {1'b0, ex_A} + {1'b0, ~ex_B} + SUB_CIN;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    if (ex_ALU_on) begin
      case (ALU_cntrl)
        OP_PASS: alu_res = ex_B;
        OP_ADD: begin
          alu_res = add_full[WIDTH-1:0];
          alu_c   = add_full[WIDTH];
          alu_v   = (ex_A[MSB] == ex_B[MSB]) & (add_full[MSB] != ex_A[MSB]);
        end
        OP_SUB: begin
          alu_res = sub_full[WIDTH-1:0];
          alu_c   = sub_full[WIDTH];
          alu_v   = (ex_A[MSB] != ex_B[MSB]) & (sub_full[MSB] != ex_A[MSB]);
        end
        OP_AND:  alu_res = ex_A & ex_B;
        OP_OR:   alu_res = ex_A | ex_B;
        OP_XOR:  alu_res = ex_A ^ ex_B;
        default: alu_res = '0;
      endcase
    end
  end

  assign ex_result = alu_res;
  assign ex_zero   = (alu_res == '0);

  // Flag next-state: overwrite NZCV only for a live, non-stalled, non-flushed flag setter.
  always_comb begin
    flag_upd = ex_valid & ex_ALU_on & ex_set_flags & ~stall & ~flush;
    nzcv_d   = nzcv_q;
    if (flag_upd) begin
      nzcv_d = {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
    end
  end

  // EX/MEM next-state: stall holds (and masks flush), flush squashes, otherwise load.
  always_comb begin
    mem_valid_d      = mem_valid_q;
    mem_reg_write_d  = mem_reg_write_q;
    mem_mem_read_d   = mem_mem_read_q;
    mem_mem_write_d  = mem_mem_write_q;
    mem_result_d     = mem_result_q;
    mem_store_data_d = mem_store_data_q;
    mem_rd_d         = mem_rd_q;
    if (!stall) begin
      if (flush) begin
        mem_valid_d      = 1'b0;
        mem_reg_write_d  = 1'b0;
        mem_mem_read_d   = 1'b0;
        mem_mem_write_d  = 1'b0;
        mem_result_d     = '0;
        mem_store_data_d = '0;
        mem_rd_d         = '0;
      end else begin
        mem_valid_d      = ex_valid;
        mem_reg_write_d  = ex_reg_write & ex_valid;
        mem_mem_read_d   = ex_mem_read & ex_valid;
        mem_mem_write_d  = ex_mem_write & ex_valid;
        mem_result_d     = alu_res;
        mem_store_data_d = ex_store_data;
        mem_rd_d         = ex_rd;
      end
    end
  end

  // State registers; reset overrides stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q           <= '0;
      mem_valid_q      <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_result_q     <= '0;
      mem_store_data_q <= '0;
      mem_rd_q         <= '0;
    end else begin
      nzcv_q           <= nzcv_d;
      mem_valid_q      <= mem_valid_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_read_q   <= mem_mem_read_d;
      mem_mem_write_q  <= mem_mem_write_d;
      mem_result_q     <= mem_result_d;
      mem_store_data_q <= mem_store_data_d;
      mem_rd_q         <= mem_rd_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_reg_write  = mem_reg_write_q;
  assign mem_mem_read   = mem_mem_read_q;
  assign mem_mem_write  = mem_mem_write_q;
  assign mem_result     = mem_result_q;
  assign mem_store_data = mem_store_data_q;
  assign mem_rd         = mem_rd_q;
  assign flag_negative  = nzcv_q[3];
  assign flag_zero      = nzcv_q[2];
  assign flag_carry     = nzcv_q[1];
  assign flag_overflow  = nzcv_q[0];

endmodule

// File: tb/tb_ex_stage_alu_flags.sv
// Scenario-driven bench for ex_stage_alu_flags with an expected-result queue.
module tb_ex_stage_alu_flags;

  localparam int unsigned W = 64;

  typedef struct packed {
    logic         valid;
    logic         rw;
    logic         mr;
    logic         mw;
    logic [4:0]   rd;
    logic [W-1:0] res;
    logic [W-1:0] sd;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
  } st_t;

  logic         clk = 1'b0;
  logic         reset, ex_valid, ex_ALU_on, ex_set_flags;
  logic [2:0]   ALU_cntrl;
  logic [W-1:0] ex_A, ex_B, ex_store_data;
  logic [4:0]   ex_rd;
  logic         ex_reg_write, ex_mem_read, ex_mem_write, stall, flush;
  logic [W-1:0] ex_result, mem_result, mem_store_data;
  logic         ex_zero, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic [4:0]   mem_rd;
  logic         flag_negative, flag_zero, flag_overflow, flag_carry;

  int   errors = 0;
  int   checks = 0;
  st_t  sb[$];
  st_t  e, o, last;
  logic [3:0] f;

  always #5 clk = ~clk;

  ex_stage_alu_flags #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ALU_on(ex_ALU_on),
    .ALU_cntrl(ALU_cntrl), .ex_set_flags(ex_set_flags), .ex_A(ex_A), .ex_B(ex_B),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .stall(stall), .flush(flush),
    .ex_result(ex_result), .ex_zero(ex_zero), .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_result(mem_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .flag_negative(flag_negative), .flag_zero(flag_zero), .flag_overflow(flag_overflow),
    .flag_carry(flag_carry)
  );

  function automatic st_t obs();
    return {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_rd, mem_result,
            mem_store_data, flag_negative, flag_zero, flag_carry, flag_overflow};
  endfunction

  function automatic st_t mk(input logic v, rw, mr, mw, input logic [4:0] rd,
                             input logic [W-1:0] res, sd, input logic [3:0] nzcv);
    return {v, rw, mr, mw, rd, res, sd, nzcv};
  endfunction

  task automatic drv(input logic v, on, input logic [2:0] op, input logic sf,
                     input logic [W-1:0] a, b, sd, input logic [4:0] rd,
                     input logic rw, mr, mw, st, fl);
    ex_valid = v; ex_ALU_on = on; ALU_cntrl = op; ex_set_flags = sf;
    ex_A = a; ex_B = b; ex_store_data = sd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; stall = st; flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(0, 0, 3'b000, 0, '0, '0, '0, 5'd0, 0, 0, 0, 0, 0);
    f = 4'b0000;
    last = mk(0, 0, 0, 0, 5'd0, '0, '0, f); sb.push_back(last);
    tick(); tick();
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_state got=%h want=%h", o, e); end
    reset = 1'b0;
  endtask

  task automatic test_adds();
    drv(1, 1, 3'b010, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h11, 5'd1, 1, 0, 0, 0, 0);
    checks++;
    if (ex_result !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL adds_comb got=%h want=%h", ex_result, 64'h8000_0000_0000_0000);
    end
    f = 4'b1001;
    last = mk(1, 1, 0, 0, 5'd1, 64'h8000_0000_0000_0000, 64'h11, f); sb.push_back(last);
    tick();
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL adds_overflow got=%h want=%h", o, e); end
  endtask

  task automatic test_subs();
    drv(1, 1, 3'b011, 1, 64'd5, 64'd5, '0, 5'd2, 1, 0, 0, 0, 0);
    checks++;
    if (ex_zero !== 1'b1) begin errors++; $display("FAIL subs_eq_zero got=%b want=1", ex_zero); end
    f = 4'b0110;
    last = mk(1, 1, 0, 0, 5'd2, '0, '0, f); sb.push_back(last);
    tick();
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL subs_equal got=%h want=%h", o, e); end
    drv(1, 1, 3'b011, 1, 64'd0, 64'd1, '0, 5'd3, 1, 0, 0, 0, 0);
    f = 4'b1000;
    last = mk(1, 1, 0, 0, 5'd3, '1, '0, f); sb.push_back(last);
    tick();
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL subs_borrow got=%h want=%h", o, e); end
  endtask

  task automatic test_logic();
    logic [2:0]   ops  [5] = '{3'b100, 3'b101, 3'b110, 3'b001, 3'b111};
    logic [W-1:0] want [5] = '{64'hF000, 64'hFFF0, 64'h0FF0, 64'h0, 64'h0};
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, ops[i], 1, 64'hF0F0, 64'hFF00, '0, 5'd4, 1, 0, 0, 0, 0);
      f = {1'b0, (want[i] == '0), 2'b00};
      last = mk(1, 1, 0, 0, 5'd4, want[i], '0, f); sb.push_back(last);
      tick();
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL logic_op%0d got=%h want=%h", i, o, e); end
    end
  endtask

  task automatic test_cbz();
    f = 4'b1000;
    drv(1, 0, 3'b011, 1, 64'd0, 64'd1, '0, 5'd0, 0, 0, 0, 0, 0);
    tick(); sb.push_back(mk(1, 0, 0, 0, 5'd0, '0, '0, f)); e = sb.pop_front();
    drv(1, 1, 3'b011, 1, 64'd0, 64'd1, '0, 5'd0, 0, 0, 0, 0, 0);
    last = mk(1, 0, 0, 0, 5'd0, '1, '0, f); sb.push_back(last);
    tick(); e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL cbz_setup got=%h want=%h", o, e); end
    drv(1, 1, 3'b000, 0, 64'd9, 64'd0, '0, 5'd0, 0, 0, 0, 0, 0);
    checks++;
    if (ex_zero !== 1'b1) begin errors++; $display("FAIL cbz_zero got=%b want=1", ex_zero); end
    last = mk(1, 0, 0, 0, 5'd0, '0, '0, f); sb.push_back(last);
    tick(); e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL cbz_zero_reg got=%h want=%h", o, e); end
    drv(1, 1, 3'b000, 0, 64'd9, 64'd3, '0, 5'd0, 0, 0, 0, 0, 0);
    checks++;
    if (ex_zero !== 1'b0 || ex_result !== 64'd3) begin
      errors++; $display("FAIL cbz_nonzero got=%b/%h want=0/3", ex_zero, ex_result);
    end
    last = mk(1, 0, 0, 0, 5'd0, 64'd3, '0, f); sb.push_back(last);
    tick(); e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL cbz_flags_hold got=%h want=%h", o, e); end
  endtask

  task automatic test_alu_off();
    drv(1, 0, 3'b010, 1, 64'd100, 64'd8, '0, 5'd7, 1, 1, 0, 0, 0);
    checks++;
    if (ex_result !== '0) begin errors++; $display("FAIL alu_off_gate got=%h want=0", ex_result); end
    drv(1, 0, 3'bxxx, 1, 64'd100, 64'd8, 64'h55, 5'd7, 1, 1, 0, 0, 0);
    checks++;
    if (ex_result !== '0 || ex_zero !== 1'b1) begin
      errors++; $display("FAIL alu_off_x got=%h/%b want=0/1", ex_result, ex_zero);
    end
    last = mk(1, 1, 1, 0, 5'd7, '0, 64'h55, f); sb.push_back(last);
    tick(); e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL ldur_no_alu got=%h want=%h", o, e); end
    checks++;
    if ($isunknown({o, ex_result, ex_zero})) begin
      errors++; $display("FAIL x_leak got=%h want=known", o);
    end
  endtask

  task automatic test_stall();
    drv(1, 1, 3'b010, 1, 64'd2, 64'd3, '0, 5'd2, 1, 0, 0, 0, 0);
    f = 4'b0000;
    last = mk(1, 1, 0, 0, 5'd2, 64'd5, '0, f); sb.push_back(last);
    tick(); e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL stall_load got=%h want=%h", o, e); end
    for (int i = 0; i < 2; i++) begin
      drv(1, 1, 3'b011, 1, 64'd9, 64'd4, 64'h77, 5'd6, 1, 0, 0, 1, 0);
      sb.push_back(last);
      tick(); e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL stall_hold%0d got=%h want=%h", i, o, e); end
    end
    drv(1, 1, 3'b011, 1, 64'd9, 64'd4, 64'h77, 5'd6, 1, 0, 0, 1, 1);
    sb.push_back(last);
    tick(); e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL stall_masks_flush got=%h want=%h", o, e); end
    drv(1, 1, 3'b011, 1, 64'd9, 64'd4, 64'h77, 5'd6, 1, 0, 0, 0, 0);
    f = 4'b0010;
    last = mk(1, 1, 0, 0, 5'd6, 64'd5, 64'h77, f); sb.push_back(last);
    tick(); e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL stall_release got=%h want=%h", o, e); end
  endtask

  task automatic test_flush_reset();
    drv(1, 1, 3'b010, 1, 64'd16, 64'd8, 64'hDEAD, 5'd3, 0, 0, 1, 0, 1);
    last = mk(0, 0, 0, 0, 5'd0, '0, '0, f); sb.push_back(last);
    tick(); e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL flush_stur got=%h want=%h", o, e); end
    drv(0, 1, 3'b010, 0, 64'd1, 64'd1, 64'hBEEF, 5'd4, 1, 1, 1, 0, 0);
    last = mk(0, 0, 0, 0, 5'd4, 64'd2, 64'hBEEF, f); sb.push_back(last);
    tick(); e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL invalid_qualify got=%h want=%h", o, e); end
    reset = 1'b1;
    drv(1, 1, 3'b010, 1, 64'd1, 64'd1, 64'hBEEF, 5'd4, 1, 1, 1, 1, 0);
    f = 4'b0000;
    last = mk(0, 0, 0, 0, 5'd0, '0, '0, f); sb.push_back(last);
    tick(); e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_over_stall got=%h want=%h", o, e); end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0]   ops [3] = '{3'b010, 3'b011, 3'b010};
    logic [W-1:0] as  [3] = '{'1, 64'd1, 64'h8000_0000_0000_0000};
    logic [W-1:0] bs  [3] = '{64'd1, 64'd2, 64'h8000_0000_0000_0000};
    logic [W-1:0] rs  [3] = '{64'd0, '1, 64'd0};
    logic [3:0]   fs  [3] = '{4'b0110, 4'b1000, 4'b0111};
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, ops[i], 1, as[i], bs[i], '0, 5'd9, 1, 0, 0, 0, 0);
      f = fs[i];
      sb.push_back(mk(1, 1, 0, 0, 5'd9, rs[i], '0, f));
    tick(); e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_%0d got=%h want=%h", i, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_subs();
    test_logic();
    test_cbz();
    test_alu_off();
    test_stall();
    test_flush_reset();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
